// File: rtl/vga_rx_pkg.sv
// Shared types and default 640x480@60 timing for the VGA receiver.
// The saturating increment keeps counters pinned at all-ones when sync disappears.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_e;

  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BP        = 48;
  localparam int DEF_H_ACT       = 640;
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BP        = 33;
  localparam int DEF_V_ACT       = 480;
  localparam int DEF_LOCK_FRAMES = 2;

  localparam logic [10:0] HCNT_MAX = 11'h7FF;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == HCNT_MAX) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/vga_edge_sync.sv
// Registers one sync pin and flags its falling edge (previous sample 1, current 0).
// Both registers reset high so an idle-high pin produces no edge after reset.
module vga_edge_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic fall_o
);

  logic sig_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sig_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sig_q  <= sig_i;
      prev_q <= sig_q;
    end
  end

  assign fall_o = prev_q & ~sig_q;

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: measures line/frame timing from hsync/vsync, locks onto the
// expected geometry and emits captured pixels with their active-area coordinates.
module vga_rx
  import vga_rx_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int H_ACT       = DEF_H_ACT,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int V_ACT       = DEF_V_ACT,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic        csi_clk25,
  input  logic        csi_reset,
  input  logic        coe_hsync,
  input  logic        coe_vsync,
  input  logic [7:0]  coe_red,
  input  logic [7:0]  coe_green,
  input  logic [7:0]  coe_blue,
  input  logic        coe_err_clr,
  output logic [23:0] coe_pixel,
  output logic [9:0]  coe_x,
  output logic [9:0]  coe_y,
  output logic        coe_pix_valid,
  output logic        coe_frame_start,
  output logic        coe_locked,
  output logic [10:0] coe_line_len,
  output logic        coe_err
);

  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  logic hfall;
  logic vfall;

  vga_edge_sync u_hsync (
    .clk_i   (csi_clk25),
    .reset_i (csi_reset),
    .sig_i   (coe_hsync),
    .fall_o  (hfall)
  );

  vga_edge_sync u_vsync (
    .clk_i   (csi_clk25),
    .reset_i (csi_reset),
    .sig_i   (coe_vsync),
    .fall_o  (vfall)
  );

  logic [23:0] rgb_q, rgb_al_q;
  logic        clr_q;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        pend_q, pend_d;
  logic        line_bad_q, line_bad_d;
  logic [7:0]  good_q, good_d;
  lock_state_e state_q, state_d;
  logic        err_set;

  logic [23:0] pixel_q;
  logic [9:0]  x_q, y_q;
  logic        valid_q, fs_q, err_q;
  logic [10:0] line_len_q;

  logic [10:0] len_meas;
  logic        len_bad;
  logic        boundary;
  logic        frame_good;
  logic        act;

  // A vsync fall coinciding with the hsync fall counts as the frame boundary itself.
  assign len_meas   = sat_inc11(hcnt_q);
  assign len_bad    = hfall && (len_meas != H_LEN);
  assign boundary   = hfall && (pend_q || vfall);
  assign frame_good = (vcnt_q == V_LAST) && !line_bad_q && !len_bad;

  always_comb begin
    hcnt_d     = hfall ? 11'd0 : sat_inc11(hcnt_q);
    vcnt_d     = vcnt_q;
    pend_d     = pend_q | vfall;
    line_bad_d = line_bad_q | len_bad;
    if (boundary) begin
      vcnt_d     = 10'd0;
      pend_d     = 1'b0;
      line_bad_d = 1'b0;
    end else if (hfall && (vcnt_q != 10'h3FF)) begin
      vcnt_d = vcnt_q + 10'd1;
    end
  end

  // An overrunning line (hcnt past H_TOTAL-1) is caught without waiting for its hsync.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_set = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (boundary) begin
          state_d = ST_CHECK;
          good_d  = 8'd0;
        end
      end
      ST_CHECK: begin
        if (boundary) begin
          if (frame_good) begin
            good_d = good_q + 8'd1;
            if ((good_q + 8'd1) >= LOCK_N) state_d = ST_LOCKED;
          end else begin
            good_d = 8'd0;
          end
        end
      end
      ST_LOCKED: begin
        if (len_bad || (boundary && (vcnt_q != V_LAST)) || (hcnt_q == H_LEN)) begin
          state_d = ST_SEARCH;
          err_set = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  assign act = (state_d == ST_LOCKED) &&
               (hcnt_q >= H_START) && (hcnt_q <= H_END) &&
               (vcnt_q >= V_START) && (vcnt_q <= V_END);

  always_ff @(posedge csi_clk25) begin
    if (csi_reset) begin
      rgb_q      <= '0;
      rgb_al_q   <= '0;
      clr_q      <= 1'b0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      pend_q     <= 1'b0;
      line_bad_q <= 1'b0;
      good_q     <= '0;
      state_q    <= ST_SEARCH;
      pixel_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      fs_q       <= 1'b0;
      line_len_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rgb_q      <= {coe_red, coe_green, coe_blue};
      rgb_al_q   <= rgb_q;
      clr_q      <= coe_err_clr;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      pend_q     <= pend_d;
      line_bad_q <= line_bad_d;
      good_q     <= good_d;
      state_q    <= state_d;
      pixel_q    <= rgb_al_q;
      x_q        <= 10'(hcnt_q - H_START);
      y_q        <= vcnt_q - V_START;
      valid_q    <= act;
      fs_q       <= act && (hcnt_q == H_START) && (vcnt_q == V_START);
      if (hfall) line_len_q <= len_meas;
      if (err_set) begin
        err_q <= 1'b1;
      end else if (clr_q) begin
        err_q <= 1'b0;
      end
    end
  end

  assign coe_pixel       = pixel_q;
  assign coe_x           = x_q;
  assign coe_y           = y_q;
  assign coe_pix_valid   = valid_q;
  assign coe_frame_start = fs_q;
  assign coe_locked      = (state_q == ST_LOCKED);
  assign coe_line_len    = line_len_q;
  assign coe_err         = err_q;

endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx on a shrunken 20x12 raster: lock, pixel capture,
// short/overrun lines, sticky error clear and mid-frame reset with relock.
module tb_vga_rx;

  localparam int H_TOTAL = 20;
  localparam int H_SYNC  = 2;
  localparam int H_BP    = 3;
  localparam int H_ACT   = 12;
  localparam int V_TOTAL = 12;
  localparam int V_SYNC  = 1;
  localparam int V_BP    = 2;
  localparam int V_ACT   = 6;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int PIX_PER_FRAME = H_ACT * V_ACT;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync, vsync, errClr;
  logic [7:0]  red, green, blue;
  logic [23:0] pixel;
  logic [9:0]  xPos, yPos;
  logic        pixValid, frameStart, locked, err;
  logic [10:0] lineLen;

  int testsRun = 0;
  int failCount = 0;
  int cyc = 0;
  int curFrame = 0;
  int validCount = 0;
  int expX = 0;
  int expY = 0;
  int lockRiseFrame = -1;
  int dropCyc = -1;
  int markCyc = -1;
  logic [31:0] dropLen = '0;
  logic [31:0] dropErr = '0;
  logic [31:0] firstFsPixel = '0;
  logic        fsSeen = 1'b0;
  logic        prevLocked = 1'b0;

  vga_rx #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT),
    .LOCK_FRAMES(2)
  ) dut (
    .csi_clk25       (clk),
    .csi_reset       (rst),
    .coe_hsync       (hsync),
    .coe_vsync       (vsync),
    .coe_red         (red),
    .coe_green       (green),
    .coe_blue        (blue),
    .coe_err_clr     (errClr),
    .coe_pixel       (pixel),
    .coe_x           (xPos),
    .coe_y           (yPos),
    .coe_pix_valid   (pixValid),
    .coe_frame_start (frameStart),
    .coe_locked      (locked),
    .coe_line_len    (lineLen),
    .coe_err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic setPins(input logic hs, input logic vs, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic clr, input logic rs);
    hsync = hs; vsync = vs; red = r; green = g; blue = b; errClr = clr; rst = rs;
  endtask

  task automatic applyStimulus(input logic hs, input logic vs, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b, input logic clr, input logic rs);
    @(negedge clk);
    setPins(hs, vs, r, g, b, clr, rs);
  endtask

  // vsync falls mid-way through the last line, so the next line start is the frame boundary.
  function automatic logic vsyncAt(input int f, input int line, input int h);
    return !(((line == V_TOTAL - 1) && (h >= 10)) || ((line == 0) && (h < 10) && (f > 0)));
  endfunction

  task automatic driveLine(input int f, input int line, input int len, input int clrH);
    for (int h = 0; h < len; h++) begin
      applyStimulus((h < H_SYNC) ? 1'b0 : 1'b1, vsyncAt(f, line, h), 8'(h - H_START),
                    8'(line), 8'(f), (h == clrH), 1'b0);
      if (h == clrH) markCyc = cyc;
    end
  endtask

  task automatic driveFrame(input int f);
    curFrame = f;
    validCount = 0;
    for (int line = 0; line < V_TOTAL; line++) driveLine(f, line, H_TOTAL, -1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pixel"}, 32'(pixel), 0);
    checkOutput({tag, "_x"}, 32'(xPos), 0);
    checkOutput({tag, "_y"}, 32'(yPos), 0);
    checkOutput({tag, "_valid"}, 32'(pixValid), 0);
    checkOutput({tag, "_fstart"}, 32'(frameStart), 0);
    checkOutput({tag, "_locked"}, 32'(locked), 0);
    checkOutput({tag, "_lineLen"}, 32'(lineLen), 0);
    checkOutput({tag, "_err"}, 32'(err), 0);
  endtask

  // Raster-order model of where the next valid pixel must land and what it must carry.
  always @(negedge clk) begin
    if (locked && !prevLocked && (lockRiseFrame < 0)) lockRiseFrame = curFrame;
    if (!locked && prevLocked && (dropCyc < 0)) begin
      dropCyc = cyc;
      dropLen = 32'(lineLen);
      dropErr = 32'(err);
    end
    prevLocked = locked;
    if (pixValid) begin
      validCount++;
      checkOutput("pixX", 32'(xPos), 32'(expX));
      checkOutput("pixY", 32'(yPos), 32'(expY));
      checkOutput("pixData", 32'(pixel), {8'd0, 8'(expX), 8'(expY + V_START), 8'(curFrame)});
      checkOutput("frameStartAt00", 32'(frameStart), 32'((expX == 0) && (expY == 0)));
      if (frameStart && !fsSeen) begin
        fsSeen = 1'b1;
        firstFsPixel = 32'(pixel);
      end
      expX++;
      if (expX == H_ACT) begin
        expX = 0;
        expY = (expY == V_ACT - 1) ? 0 : expY + 1;
      end
    end else if (frameStart) begin
      checkOutput("frameStartNoValid", 32'(frameStart), 0);
    end
    if (!locked) begin
      expX = 0;
      expY = 0;
    end
  end

  initial begin
    setPins(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    repeat (5) applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);

    for (int f = 0; f < 3; f++) driveFrame(f);
    checkOutput("lockedBeforeBoundary3", 32'(locked), 0);
    driveFrame(3);
    checkOutput("lockedAfterBoundary3", 32'(locked), 1);
    checkOutput("lockRiseFrame", 32'(lockRiseFrame), 3);
    checkOutput("validFrame3", 32'(validCount), 32'(PIX_PER_FRAME));
    checkOutput("firstFsPixel", firstFsPixel, 32'h00_00_03_03);
    driveFrame(4);
    checkOutput("validFrame4", 32'(validCount), 32'(PIX_PER_FRAME));
    checkOutput("lineLenNominal", 32'(lineLen), 32'(H_TOTAL));
    checkOutput("errWhileLocked", 32'(err), 0);

    curFrame = 5;
    for (int line = 0; line < 4; line++) driveLine(5, line, H_TOTAL, -1);
    driveLine(5, 4, H_TOTAL - 1, -1);
    driveLine(5, 5, H_TOTAL, 0);
    checkOutput("dropLineLen", dropLen, 32'(H_TOTAL - 1));
    checkOutput("dropErr", dropErr, 1);
    checkOutput("dropLatency", 32'(dropCyc - markCyc), 2);
    checkOutput("lockedAfterShortLine", 32'(locked), 0);
    driveLine(5, 6, H_TOTAL, -1);
    checkOutput("errSetWinsOverClr", 32'(err), 1);
    driveLine(5, 7, H_TOTAL, 10);
    checkOutput("errClearedByLonePulse", 32'(err), 0);
    for (int line = 8; line < V_TOTAL; line++) driveLine(5, line, H_TOTAL, -1);

    driveFrame(6);
    driveFrame(7);
    checkOutput("lockedBeforeRelock", 32'(locked), 0);
    driveFrame(8);
    checkOutput("relocked", 32'(locked), 1);
    checkOutput("validFrame8", 32'(validCount), 32'(PIX_PER_FRAME));

    validCount = 0;
    repeat (3000) applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    checkOutput("stuckLocked", 32'(locked), 0);
    checkOutput("stuckErr", 32'(err), 1);
    checkOutput("stuckValid", 32'(validCount), 0);
    curFrame = 9;
    driveLine(9, 0, H_TOTAL, -1);
    checkOutput("stuckLineLenSat", 32'(lineLen), 2047);
    for (int line = 1; line < V_TOTAL; line++) driveLine(9, line, H_TOTAL, -1);

    driveFrame(10);
    curFrame = 11;
    for (int line = 0; line < 5; line++) driveLine(11, line, H_TOTAL, -1);
    checkOutput("lockedBeforeMidReset", 32'(locked), 1);
    for (int h = 0; h <= 8; h++)
      applyStimulus((h < H_SYNC) ? 1'b0 : 1'b1, 1'b1, 8'(h - H_START), 8'd5, 8'd11, 1'b0, (h == 8));
    @(negedge clk);
    checkAllZero("midReset");
    setPins(1'b1, 1'b1, 8'(9 - H_START), 8'd5, 8'd11, 1'b0, 1'b0);
    for (int h = 10; h < H_TOTAL; h++)
      applyStimulus(1'b1, 1'b1, 8'(h - H_START), 8'd5, 8'd11, 1'b0, 1'b0);
    for (int line = 6; line < V_TOTAL; line++) driveLine(11, line, H_TOTAL, -1);

    driveFrame(12);
    driveFrame(13);
    checkOutput("lockedAfterOneGoodFrame", 32'(locked), 0);
    driveFrame(14);
    checkOutput("relockAfterReset", 32'(locked), 1);
    checkOutput("validFrame14", 32'(validCount), 32'(PIX_PER_FRAME));
    checkOutput("errAfterReset", 32'(err), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
